// File: rtl/key_expansion_seq_if.sv
// Handshake and schedule bus between the AES key schedule generator and its user.
interface key_expansion_seq_if #(
  parameter int Nk = 4,
  parameter int Nr = 10
);
  logic                    start;
  logic [32*Nk-1:0]        key;
  logic [128*(Nr+1)-1:0]   w;
  logic                    busy;
  logic                    done;
  logic                    valid;

  modport master (output start, key, input w, busy, done, valid);
  modport slave  (input start, key, output w, busy, done, valid);
endinterface

// File: rtl/key_expansion_seq.sv
// Iterative AES key schedule: one 32-bit schedule word per clock through a single
// shared 4-byte S-box, producing the flat round-key bus for AES-128/192/256.
module key_expansion_seq #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic               clk,
  input  logic               reset,
  key_expansion_seq_if.slave bus
);
  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int PW = $clog2(Nk);
  localparam logic [IW-1:0] LAST       = IW'(NW - 1);
  localparam logic [IW-1:0] NK_W       = IW'(Nk);
  localparam logic [IW-1:0] RCON_LIMIT = IW'(NW - 1 - Nk);
  localparam logic [PW-1:0] POS_LAST   = PW'(Nk - 1);
  localparam logic [PW-1:0] POS_HALF   = PW'(Nk / 2);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t        state, state_next;
  logic [31:0]   words [NW];
  logic [IW-1:0] word_idx;
  logic [PW-1:0] pos;
  logic [7:0]    rcon;
  logic          done_flag, valid_flag;
  logic          load, step, finish;
  logic [31:0]   prev, sbox_in, sub, temp, new_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;

    // pos tracks word_idx % Nk incrementally so Nk=6 needs no divider
    prev    = words[word_idx - IW'(1)];
    sbox_in = (pos == '0) ? {prev[23:0], prev[31:24]} : prev;
    sub     = {SBOX[sbox_in[31:24]], SBOX[sbox_in[23:16]],
               SBOX[sbox_in[15:8]],  SBOX[sbox_in[7:0]]};
    temp    = prev;
    if (pos == '0)
      temp = sub ^ {rcon, 24'h0};
    else if ((Nk == 8) && (pos == POS_HALF))
      temp = sub;
    new_word = words[word_idx - NK_W] ^ temp;

    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (word_idx == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < NW; n++) words[n] <= '0;
      word_idx   <= '0;
      pos        <= '0;
      rcon       <= 8'h01;
      done_flag  <= 1'b0;
      valid_flag <= 1'b0;
    end else begin
      done_flag <= finish;
      if (load) begin
        for (int unsigned n = 0; n < Nk; n++) words[n] <= bus.key[32*(Nk-n)-1 -: 32];
        for (int unsigned n = Nk; n < NW; n++) words[n] <= '0;
        word_idx   <= NK_W;
        pos        <= '0;
        rcon       <= 8'h01;
        valid_flag <= 1'b0;
      end
      if (step) begin
        words[word_idx] <= new_word;
        if (!finish) word_idx <= word_idx + IW'(1);
        pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
        // rcon holds its final value once no later word needs it
        if ((pos == '0) && (word_idx <= RCON_LIMIT)) rcon <= xtime(rcon);
        if (finish) valid_flag <= 1'b1;
      end
    end
  end

  assign bus.busy  = (state == EXPAND);
  assign bus.done  = done_flag;
  assign bus.valid = valid_flag;

  always_comb begin
    bus.w = '0;
    for (int unsigned n = 0; n < NW; n++) bus.w[128*(n/4) + 32*(3-n%4) +: 32] = words[n];
  end
endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for the AES key schedule generator using FIPS-197 appendix A vectors.
module tb_key_expansion_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  key_expansion_seq_if #(.Nk(4), .Nr(10)) bus128 ();
  key_expansion_seq_if #(.Nk(6), .Nr(12)) bus192 ();
  key_expansion_seq_if #(.Nk(8), .Nr(14)) bus256 ();

  key_expansion_seq #(.Nk(4), .Nr(10)) u128 (.clk(clk), .reset(reset), .bus(bus128.slave));
  key_expansion_seq #(.Nk(6), .Nr(12)) u192 (.clk(clk), .reset(reset), .bus(bus192.slave));
  key_expansion_seq #(.Nk(8), .Nr(14)) u256 (.clk(clk), .reset(reset), .bus(bus256.slave));

  localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK10_Z = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct {
    string         name;
    int unsigned   off;
    int unsigned   len;
    logic [127:0]  exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [127:0] len_mask(input int unsigned len);
    return (len >= 128) ? '1 : ((128'd1 << len) - 128'd1);
  endfunction

  task automatic push_a();
    sbq.push_back('{"rk0_key", 0, 128, KEY128});
    sbq.push_back('{"word4", 224, 32, 128'h00000000_00000000_00000000_a0fafe17});
    sbq.push_back('{"rk10", 1280, 128, RK10_A});
  endtask

  task automatic drain_128();
    exp_t e;
    logic [127:0] got;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = bus128.w[e.off +: 128] & len_mask(e.len);
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL aes128_%s: got=%h exp=%h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus128.start = 1'b1;
    bus128.key = KEY128;
    repeat (2) @(negedge clk);
    total++;
    if (bus128.w !== '0) begin bad++; $display("FAIL reset_w: nonzero_bits=%0d exp=0", $countones(bus128.w)); end
    total++;
    if ({bus128.busy, bus128.done, bus128.valid} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: busy/done/valid=%b exp=000", {bus128.busy, bus128.done, bus128.valid});
    end
    bus128.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus128.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got=%b exp=0", bus128.busy); end
  endtask

  task automatic test_aes128();
    int cyc = -1;
    push_a();
    bus128.key = KEY128;
    bus128.start = 1'b1;
    @(negedge clk);
    bus128.start = 1'b0;
    bus128.key = '1;
    total++;
    if ({bus128.busy, bus128.valid} !== 2'b10) begin
      bad++; $display("FAIL aes128_busy: busy/valid=%b exp=10", {bus128.busy, bus128.valid});
    end
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus128.done) begin cyc = n; break; end
    end
    total++;
    if (cyc != 40) begin bad++; $display("FAIL aes128_latency: got=%0d exp=40", cyc); end
    total++;
    if ({bus128.busy, bus128.valid} !== 2'b01) begin
      bad++; $display("FAIL aes128_done_flags: busy/valid=%b exp=01", {bus128.busy, bus128.valid});
    end
    drain_128();
    @(negedge clk);
    total++;
    if ({bus128.done, bus128.valid} !== 2'b01) begin
      bad++; $display("FAIL aes128_after_done: done/valid=%b exp=01", {bus128.done, bus128.valid});
    end
  endtask

  task automatic test_aes192();
    int cyc = -1;
    exp_t e;
    logic [127:0] got;
    sbq.push_back('{"rk0_key", 0, 128, KEY192[191:64]});
    sbq.push_back('{"rk12", 1536, 128, 128'he98ba06f448c773c8ecc720401002202});
    bus192.key = KEY192;
    bus192.start = 1'b1;
    @(negedge clk);
    bus192.start = 1'b0;
    bus192.key = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus192.done) begin cyc = n; break; end
    end
    total++;
    if (cyc != 46) begin bad++; $display("FAIL aes192_latency: got=%0d exp=46", cyc); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = bus192.w[e.off +: 128] & len_mask(e.len);
      total++;
      if (got !== e.exp) begin bad++; $display("FAIL aes192_%s: got=%h exp=%h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_aes256();
    int cyc = -1;
    exp_t e;
    logic [127:0] got;
    sbq.push_back('{"rk0_key", 0, 128, KEY256[255:128]});
    sbq.push_back('{"rk1_key", 128, 128, KEY256[127:0]});
    sbq.push_back('{"word12", 480, 32, 128'h00000000_00000000_00000000_a8b09c1a});
    sbq.push_back('{"rk14", 1792, 128, 128'hfe4890d1e6188d0b046df344706c631e});
    bus256.key = KEY256;
    bus256.start = 1'b1;
    @(negedge clk);
    bus256.start = 1'b0;
    bus256.key = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus256.done) begin cyc = n; break; end
    end
    total++;
    if (cyc != 52) begin bad++; $display("FAIL aes256_latency: got=%0d exp=52", cyc); end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      got = bus256.w[e.off +: 128] & len_mask(e.len);
      total++;
      if (got !== e.exp) begin bad++; $display("FAIL aes256_%s: got=%h exp=%h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_start_busy();
    int cyc = -1;
    int dones = 0;
    push_a();
    bus128.key = KEY128;
    bus128.start = 1'b1;
    @(negedge clk);
    bus128.start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 10) begin bus128.start = 1'b1; bus128.key = '0; end
      if (n == 11) bus128.start = 1'b0;
      if (bus128.done) begin
        dones++;
        if (cyc < 0) begin cyc = n; drain_128(); end
      end
    end
    total++;
    if (cyc != 40) begin bad++; $display("FAIL busy_start_latency: got=%0d exp=40", cyc); end
    total++;
    if (dones != 1) begin bad++; $display("FAIL busy_start_done_count: got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    bus128.key = KEY128;
    bus128.start = 1'b1;
    @(negedge clk);
    bus128.start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (bus128.w !== '0) begin bad++; $display("FAIL midreset_w: nonzero_bits=%0d exp=0", $countones(bus128.w)); end
    total++;
    if ({bus128.busy, bus128.done, bus128.valid} !== 3'b000) begin
      bad++; $display("FAIL midreset_flags: busy/done/valid=%b exp=000", {bus128.busy, bus128.done, bus128.valid});
    end
    test_aes128();
  endtask

  task automatic test_back_to_back();
    int cyc = -1;
    push_a();
    bus128.key = KEY128;
    bus128.start = 1'b1;
    @(negedge clk);
    bus128.key = '0;
    total++;
    if (bus128.valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got=%b exp=0", bus128.valid); end
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus128.done) begin cyc = n; break; end
    end
    total++;
    if (cyc != 40 || bus128.valid !== 1'b1) begin
      bad++; $display("FAIL b2b_first: latency=%0d valid=%b exp=40/1", cyc, bus128.valid);
    end
    drain_128();
    sbq.push_back('{"rk10_zero", 1280, 128, RK10_Z});
    @(negedge clk);
    total++;
    if ({bus128.busy, bus128.done, bus128.valid} !== 3'b100) begin
      bad++; $display("FAIL b2b_restart: busy/done/valid=%b exp=100", {bus128.busy, bus128.done, bus128.valid});
    end
    cyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus128.done) begin cyc = n; bus128.start = 1'b0; break; end
    end
    bus128.start = 1'b0;
    total++;
    if (cyc != 40 || bus128.valid !== 1'b1) begin
      bad++; $display("FAIL b2b_second: latency=%0d valid=%b exp=40/1", cyc, bus128.valid);
    end
    drain_128();
    @(negedge clk);
    total++;
    if (bus128.busy !== 1'b0) begin bad++; $display("FAIL b2b_stop: busy=%b exp=0", bus128.busy); end
  endtask

  initial begin
    reset = 1'b1;
    bus128.start = 1'b0; bus128.key = '0;
    bus192.start = 1'b0; bus192.key = '0;
    bus256.start = 1'b0; bus256.key = '0;
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
